pressure_controller: RTL and testbench

Chamber-side responder for the airlock pressure handshake. It accepts single-cycle `startPressurizing` / `startDepressurizing` requests from the arrival and departure workflow FSMs, runs a timed pump or vent ramp under a door interlock, and reports chamber state back on `isHighPressure`. It sits between the workflow controllers and the pump/vent actuator drivers.

---
 rtl/airlock_pkg.sv | 19 +
 rtl/pressure_controller_if.sv | 25 ++
 rtl/pressure_controller_ramp_timer.sv | 26 ++
 rtl/pressure_controller.sv | 102 ++++++++++
 tb/tb_pressure_controller.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/airlock_pkg.sv
// Shared airlock definitions: chamber state encoding and default ramp lengths,
// common to the pressure controller and the arrival/departure workflows.
package airlock_pkg;

   typedef enum logic [1:0] {
      LOW            = 2'b00,
      PRESSURIZING   = 2'b01,
      HIGH           = 2'b10,
      DEPRESSURIZING = 2'b11
   } state_e;

   localparam int PRESS_CYCLES_DEF   = 5;
   localparam int DEPRESS_CYCLES_DEF = 7;

   function automatic logic f_doors_closed(input logic od_closed, input logic id_closed);
      return od_closed & id_closed;
   endfunction

endpackage

// File: rtl/pressure_controller_if.sv
// Request/door/status bundle between the workflow controllers (master)
// and the chamber-side pressure controller (slave).
interface pressure_controller_if;
   logic startPressurizing;
   logic startDepressurizing;
   logic odClosed;
   logic idClosed;
   logic isHighPressure;
   logic busy;
   logic pumpOn;
   logic ventOn;
   logic hold;
   logic done;
   logic reject;

   modport master (
      output startPressurizing, startDepressurizing, odClosed, idClosed,
      input  isHighPressure, busy, pumpOn, ventOn, hold, done, reject
   );

   modport slave (
      input  startPressurizing, startDepressurizing, odClosed, idClosed,
      output isHighPressure, busy, pumpOn, ventOn, hold, done, reject
   );
endinterface

// File: rtl/pressure_controller_ramp_timer.sv
// Ramp cycle counter: counts enabled cycles from zero and flags when the
// count has reached the supplied limit (ramp length minus one).
module ramp_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             terminal
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clock) begin
      if (clear) begin
         r_cnt <= '0;
      end else if (enable) begin
         if (terminal) r_cnt <= '0;
         else          r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign terminal = (r_cnt == limit);

endmodule

// File: rtl/pressure_controller.sv
// Chamber pressure responder: accepts pressurize/depressurize pulses, runs a
// timed pump/vent ramp under the door interlock and reports chamber state.
module pressure_controller
   import airlock_pkg::*;
#(
   parameter int PRESS_CYCLES   = PRESS_CYCLES_DEF,
   parameter int DEPRESS_CYCLES = DEPRESS_CYCLES_DEF,
   parameter int CNT_W          = 8,
   parameter int RESET_HIGH     = 1
) (
   input logic                  clock,
   input logic                  reset,
   pressure_controller_if.slave bus
);

   localparam state_e           RST_STATE = (RESET_HIGH != 0) ? HIGH : LOW;
   localparam logic [CNT_W-1:0] PRESS_LIM = CNT_W'(PRESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEPR_LIM  = CNT_W'(DEPRESS_CYCLES - 1);

   state_e           r_state, w_state_nxt;
   logic             r_done, r_reject;
   logic             w_done_nxt, w_reject_nxt, w_accept;
   logic             w_doors, w_req, w_ramp, w_terminal;
   logic [CNT_W-1:0] w_limit;

   assign w_doors = f_doors_closed(bus.odClosed, bus.idClosed);
   assign w_req   = bus.startPressurizing | bus.startDepressurizing;
   assign w_ramp  = r_state[0];
   assign w_limit = (r_state == DEPRESSURIZING) ? DEPR_LIM : PRESS_LIM;

   // Counter restarts on reset and on every accepted request; it only advances
   // while ramping with both doors shut, so an open door freezes progress.
   ramp_timer #(.CNT_W(CNT_W)) u_timer (
      .clock    (clock),
      .clear    (reset | w_accept),
      .enable   (w_ramp & w_doors),
      .limit    (w_limit),
      .terminal (w_terminal)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= RST_STATE;
         r_done   <= 1'b0;
         r_reject <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_done   <= w_done_nxt;
         r_reject <= w_reject_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      w_done_nxt   = 1'b0;
      w_reject_nxt = 1'b0;
      case (r_state)
         LOW: begin
            if (bus.startPressurizing && !bus.startDepressurizing && w_doors) begin
               w_state_nxt = PRESSURIZING;
               w_accept    = 1'b1;
            end else begin
               w_reject_nxt = w_req;
            end
         end
         HIGH: begin
            if (bus.startDepressurizing && !bus.startPressurizing && w_doors) begin
               w_state_nxt = DEPRESSURIZING;
               w_accept    = 1'b1;
            end else begin
               w_reject_nxt = w_req;
            end
         end
         PRESSURIZING: begin
            w_reject_nxt = w_req;
            if (w_doors && w_terminal) begin
               w_state_nxt = HIGH;
               w_done_nxt  = 1'b1;
            end
         end
         DEPRESSURIZING: begin
            w_reject_nxt = w_req;
            if (w_doors && w_terminal) begin
               w_state_nxt = LOW;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = RST_STATE;
      endcase
   end

   // Pressure level is the high state bit: HIGH and DEPRESSURIZING both read high.
   assign bus.isHighPressure = r_state[1];
   assign bus.busy           = w_ramp;
   assign bus.pumpOn         = (r_state == PRESSURIZING) & w_doors;
   assign bus.ventOn         = (r_state == DEPRESSURIZING) & w_doors;
   assign bus.hold           = w_ramp & ~w_doors;
   assign bus.done           = r_done;
   assign bus.reject         = r_reject;

endmodule

// File: tb/tb_pressure_controller.sv
// Bench for pressure_controller: two instances (reset to HIGH and to LOW)
// compared every cycle against a remaining-cycles model, plus directed timing checks.
module tb_pressure_controller;

   localparam int PN = 5;
   localparam int DN = 7;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic sp = 1'b0, sd = 1'b0, od = 1'b1, idc = 1'b1;

   always #5 clock = ~clock;

   pressure_controller_if ifa();
   pressure_controller_if ifb();

   assign ifa.startPressurizing   = sp;
   assign ifa.startDepressurizing = sd;
   assign ifa.odClosed            = od;
   assign ifa.idClosed            = idc;
   assign ifb.startPressurizing   = sp;
   assign ifb.startDepressurizing = sd;
   assign ifb.odClosed            = od;
   assign ifb.idClosed            = idc;

   pressure_controller #(.RESET_HIGH(1)) dut_a (.clock(clock), .reset(reset), .bus(ifa.slave));
   pressure_controller #(.RESET_HIGH(0)) dut_b (.clock(clock), .reset(reset), .bus(ifb.slave));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int e0    = 0;
   bit armed = 1'b0;

   // Model: pressure level, whether a ramp runs, and closed-door cycles still owed.
   bit m_high [2];
   bit m_ramp [2];
   bit m_done [2];
   bit m_rej  [2];
   int m_rem  [2];
   bit rh     [2] = '{1'b1, 1'b0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_inst(input int k, input logic hi, input logic bsy, input logic pmp,
                             input logic vnt, input logic hld, input logic dn, input logic rj);
      bit doors;
      doors = od & idc;
      chk($sformatf("inst%0d isHighPressure", k), hi,  m_high[k]);
      chk($sformatf("inst%0d busy", k),           bsy, m_ramp[k]);
      chk($sformatf("inst%0d pumpOn", k),         pmp, m_ramp[k] && !m_high[k] && doors);
      chk($sformatf("inst%0d ventOn", k),         vnt, m_ramp[k] && m_high[k] && doors);
      chk($sformatf("inst%0d hold", k),           hld, m_ramp[k] && !doors);
      chk($sformatf("inst%0d done", k),           dn,  m_done[k]);
      chk($sformatf("inst%0d reject", k),         rj,  m_rej[k]);
   endtask

   always @(posedge clock) begin
      bit doors, want;
      cyc++;
      doors = od & idc;
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_high[k] = rh[k]; m_ramp[k] = 1'b0; m_rem[k] = 0;
            m_done[k] = 1'b0;  m_rej[k]  = 1'b0;
         end else begin
            m_done[k] = 1'b0;
            m_rej[k]  = 1'b0;
            if (m_ramp[k]) begin
               m_rej[k] = sp | sd;
               if (doors) begin
                  m_rem[k]--;
                  if (m_rem[k] == 0) begin
                     m_ramp[k] = 1'b0;
                     m_high[k] = !m_high[k];
                     m_done[k] = 1'b1;
                  end
               end
            end else begin
               want = m_high[k] ? (sd && !sp) : (sp && !sd);
               if (want && doors) begin
                  m_ramp[k] = 1'b1;
                  m_rem[k]  = m_high[k] ? DN : PN;
               end else begin
                  m_rej[k] = sp | sd;
               end
            end
         end
      end
      if (reset) armed = 1'b1;
      #1;
      if (armed) begin
         check_inst(0, ifa.isHighPressure, ifa.busy, ifa.pumpOn, ifa.ventOn, ifa.hold, ifa.done, ifa.reject);
         check_inst(1, ifb.isHighPressure, ifb.busy, ifb.pumpOn, ifb.ventOn, ifb.hold, ifb.done, ifb.reject);
      end
   end

   task automatic req(input bit p, input bit d, output logic rej);
      @(negedge clock);
      sp = p; sd = d;
      @(posedge clock);
      #1;
      e0  = cyc;
      rej = ifa.reject;
      @(negedge clock);
      sp = 1'b0; sd = 1'b0;
   endtask

   task automatic wait_done(output int el);
      el = -1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (ifa.done === 1'b1) begin
            el = cyc - e0;
            break;
         end
      end
      if (el < 0) begin
         total++;
         bad++;
         $display("FAIL done_timeout: done never seen within 40 cycles, required one pulse");
      end
   endtask

   initial begin
      logic rj;
      int   el;
      int   dcount;

      repeat (2) @(posedge clock);
      #1;
      chk("rst A isHighPressure", ifa.isHighPressure, 1);
      chk("rst B isHighPressure", ifb.isHighPressure, 0);
      chk("rst A busy", ifa.busy, 0);
      chk("rst B busy", ifb.busy, 0);
      chk("rst A done/reject", {ifa.done, ifa.reject}, 0);
      chk("rst A pump/vent/hold", {ifa.pumpOn, ifa.ventOn, ifa.hold}, 0);
      @(negedge clock);
      reset = 1'b0;

      // Nominal depressurize then pressurize
      req(1'b0, 1'b1, rj);
      chk("depress accept no reject", rj, 0);
      chk("depress ventOn at E0", ifa.ventOn, 1);
      wait_done(el);
      chk("depress length", el, 7);
      chk("after depress low", ifa.isHighPressure, 0);
      req(1'b1, 1'b0, rj);
      wait_done(el);
      chk("press length", el, 5);
      chk("after press high", ifa.isHighPressure, 1);

      // Refusals
      req(1'b1, 1'b0, rj);
      chk("press while HIGH reject", rj, 1);
      @(posedge clock); #1;
      chk("reject one cycle", ifa.reject, 0);
      req(1'b0, 1'b1, rj);
      wait_done(el);
      req(1'b1, 1'b1, rj);
      chk("both requests reject", rj, 1);
      chk("both requests stay LOW", {ifa.isHighPressure, ifa.busy}, 0);
      idc = 1'b0;
      req(1'b1, 1'b0, rj);
      idc = 1'b1;
      chk("inner door open reject", rj, 1);

      // Door hold during pressurize from cnt=2
      req(1'b1, 1'b0, rj);
      @(negedge clock);
      @(negedge clock);
      od = 1'b0;
      repeat (3) begin
         @(posedge clock); #1;
         chk("hold asserted", ifa.hold, 1);
         chk("pump off in hold", ifa.pumpOn, 0);
      end
      @(negedge clock);
      od = 1'b1;
      wait_done(el);
      chk("held press length", el, 8);

      // Request mid-ramp is refused and schedule unchanged
      req(1'b0, 1'b1, rj);
      wait_done(el);
      req(1'b1, 1'b0, rj);
      @(negedge clock);
      sd = 1'b1;
      @(posedge clock); #1;
      chk("mid-ramp reject", ifa.reject, 1);
      @(negedge clock);
      sd = 1'b0;
      wait_done(el);
      chk("mid-ramp press length", el, 5);

      // Reset at cnt=3 of depressurize
      req(1'b0, 1'b1, rj);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("mid reset busy", ifa.busy, 0);
      chk("mid reset high", ifa.isHighPressure, 1);
      @(negedge clock);
      reset  = 1'b0;
      dcount = 0;
      repeat (10) begin
         @(posedge clock); #1;
         if (ifa.done === 1'b1) dcount++;
      end
      chk("no done after reset", dcount, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         sp    = ($urandom_range(0, 5) == 0);
         sd    = ($urandom_range(0, 5) == 0);
         od    = ($urandom_range(0, 7) != 0);
         idc   = ($urandom_range(0, 7) != 0);
         reset = ($urandom_range(0, 199) == 0);
      end
      @(negedge clock);
      sp = 1'b0; sd = 1'b0; od = 1'b1; idc = 1'b1; reset = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
